// File: rtl/vliw_fetch_stage_pkg.sv
// Shared VLIW slot field positions, halt encoding and fetch FSM states.
// Decode and hazard detection import these as well.
package vliw_fetch_stage_pkg;

    localparam int ADD_SHIFT_BAR_BIT = 15;
    localparam int RD_ADD_MSB        = 8;
    localparam int RD_ADD_LSB        = 6;
    localparam int RM_SHIFT_MSB      = 5;
    localparam int RM_SHIFT_LSB      = 3;
    localparam int MEMREAD_BIT       = 15;
    localparam int MEMWRITE_BIT      = 14;
    localparam int RN_MSB            = 5;
    localparam int RN_LSB            = 3;
    localparam int RD_MSB            = 2;
    localparam int RD_LSB            = 0;

    localparam int SLOT0_BASE = 16;
    localparam int SLOT1_BASE = 0;

    localparam logic [31:0] HALT_BUNDLE_DEF = 32'hFFFF_FFFF;

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

endpackage

// File: rtl/vliw_fetch_stage_field_extract.sv
// IF/ID field extraction: registered bundle + valid -> hazard/decode fields.
// Memory controls are gated by valid so bubbles never look like loads/stores.
module if_id_field_extract
    import vliw_fetch_stage_pkg::*;
(
    input  logic [31:0] bundle_i,
    input  logic        valid_i,
    output logic        add_shift_bar_o,
    output logic [2:0]  regrd_add_o,
    output logic [2:0]  regrm_shift_o,
    output logic        memread_o,
    output logic        memwrite_o,
    output logic [2:0]  rn1_o,
    output logic [2:0]  rd1_o
);

    logic unused_bits;
    assign unused_bits = ^bundle_i;

    assign add_shift_bar_o = bundle_i[SLOT0_BASE + ADD_SHIFT_BAR_BIT];
    assign regrd_add_o     = bundle_i[SLOT0_BASE + RD_ADD_MSB :
                                      SLOT0_BASE + RD_ADD_LSB];
    assign regrm_shift_o   = bundle_i[SLOT0_BASE + RM_SHIFT_MSB :
                                      SLOT0_BASE + RM_SHIFT_LSB];
    assign memread_o       = bundle_i[SLOT1_BASE + MEMREAD_BIT] & valid_i;
    assign memwrite_o      = bundle_i[SLOT1_BASE + MEMWRITE_BIT] & valid_i;
    assign rn1_o           = bundle_i[SLOT1_BASE + RN_MSB :
                                      SLOT1_BASE + RN_LSB];
    assign rd1_o           = bundle_i[SLOT1_BASE + RD_MSB :
                                      SLOT1_BASE + RD_LSB];

endmodule

// File: rtl/vliw_fetch_stage.sv
// VLIW fetch stage with IF/ID register and RUN/HALTED fetch FSM.
// Optional STALL_CNT_EN adds a saturating 16-bit stall counter output.
module vliw_fetch_stage
    import vliw_fetch_stage_pkg::*;
#(
    parameter int               PC_W        = 8,
    parameter logic [PC_W-1:0]  RESET_PC    = '0,
    parameter logic [31:0]      HALT_BUNDLE = HALT_BUNDLE_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pc_write,
    input  logic            if_id_write,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [PC_W-1:0] if_id_pc,
    output logic [31:0]     if_id_bundle,
    output logic            if_id_valid,
    output logic            if_id_add_shift_bar,
    output logic [2:0]      if_id_regRd_add_6,
    output logic [2:0]      if_id_regRm_shift,
    output logic            if_id_memRead,
    output logic            if_id_memWrite,
    output logic [2:0]      if_id_rn1,
    output logic [2:0]      if_id_rd1,
`ifdef STALL_CNT_EN
    output logic [15:0]     stall_count,
`endif
    output logic            halted
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] ipc_q, ipc_d;
    logic [31:0]     bun_q, bun_d;
    logic            vld_q, vld_d;
    logic [0:0]      st_q, st_d;
    logic            halt_hit;

    // Halt only triggers when the halt bundle is actually being loaded
    assign halt_hit = (st_q == ST_RUN) && if_id_write && !branch_taken
                      && (imem_rdata == HALT_BUNDLE);

    always_comb begin
        pc_d  = pc_q;
        ipc_d = ipc_q;
        bun_d = bun_q;
        vld_d = vld_q;
        st_d  = st_q;
        if (branch_taken) begin
            pc_d  = branch_target;
            st_d  = ST_RUN;
            vld_d = 1'b0;
            bun_d = '0;
        end else begin
            if (st_q == ST_RUN && pc_write && !halt_hit)
                pc_d = pc_q + 1'b1;
            if (if_id_write) begin
                if (st_q == ST_HALTED || halt_hit) begin
                    vld_d = 1'b0;
                    bun_d = '0;
                end else begin
                    vld_d = 1'b1;
                    bun_d = imem_rdata;
                    ipc_d = pc_q;
                end
            end
            if (halt_hit)
                st_d = ST_HALTED;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            ipc_q <= '0;
            bun_q <= '0;
            vld_q <= 1'b0;
            st_q  <= ST_RUN;
        end else begin
            pc_q  <= pc_d;
            ipc_q <= ipc_d;
            bun_q <= bun_d;
            vld_q <= vld_d;
            st_q  <= st_d;
        end
    end

`ifdef STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt_q <= '0;
        else if (st_q == ST_RUN && !branch_taken
                 && (!pc_write || !if_id_write)
                 && stall_cnt_q != 16'hFFFF)
            stall_cnt_q <= stall_cnt_q + 16'd1;
    end

    assign stall_count = stall_cnt_q;
`endif

    assign imem_addr    = pc_q;
    assign if_id_pc     = ipc_q;
    assign if_id_bundle = bun_q;
    assign if_id_valid  = vld_q;
    assign halted       = (st_q == ST_HALTED);

    if_id_field_extract u_fields (
        .bundle_i        (bun_q),
        .valid_i         (vld_q),
        .add_shift_bar_o (if_id_add_shift_bar),
        .regrd_add_o     (if_id_regRd_add_6),
        .regrm_shift_o   (if_id_regRm_shift),
        .memread_o       (if_id_memRead),
        .memwrite_o      (if_id_memWrite),
        .rn1_o           (if_id_rn1),
        .rd1_o           (if_id_rd1)
    );

endmodule

// File: tb/tb_vliw_fetch_stage.sv
// Bench for vliw_fetch_stage: reference-model scoreboard plus field vectors.
module tb_vliw_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_write;
    logic        if_id_write;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [7:0]  if_id_pc;
    logic [31:0] if_id_bundle;
    logic        if_id_valid;
    logic        f_asb;
    logic [2:0]  f_rd6;
    logic [2:0]  f_rm;
    logic        f_mr;
    logic        f_mw;
    logic [2:0]  f_rn;
    logic [2:0]  f_rd;
    logic        halted;
`ifdef STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    logic [31:0] mem [256];

    assign imem_rdata = mem[imem_addr];

    always #5 clk = ~clk;

    vliw_fetch_stage dut (
        .clk                 (clk),
        .reset               (reset),
        .pc_write            (pc_write),
        .if_id_write         (if_id_write),
        .branch_taken        (branch_taken),
        .branch_target       (branch_target),
        .imem_addr           (imem_addr),
        .imem_rdata          (imem_rdata),
        .if_id_pc            (if_id_pc),
        .if_id_bundle        (if_id_bundle),
        .if_id_valid         (if_id_valid),
        .if_id_add_shift_bar (f_asb),
        .if_id_regRd_add_6   (f_rd6),
        .if_id_regRm_shift   (f_rm),
        .if_id_memRead       (f_mr),
        .if_id_memWrite      (f_mw),
        .if_id_rn1           (f_rn),
        .if_id_rd1           (f_rd),
`ifdef STALL_CNT_EN
        .stall_count         (stall_count),
`endif
        .halted              (halted)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  pc;
        logic [7:0]  ipc;
        logic [31:0] bun;
        logic        vld;
        logic        hlt;
    } exp_t;

    exp_t sb[$];

    // Reference model of the fetch stage
    logic [7:0]  m_pc;
    logic [7:0]  m_ipc;
    logic [31:0] m_bun;
    logic        m_vld;
    logic        m_hlt;

    task automatic cycle();
        exp_t e;
        logic hit;
        if (reset) begin
            m_pc = 8'h00; m_ipc = 8'h00; m_bun = '0;
            m_vld = 1'b0; m_hlt = 1'b0;
        end else if (branch_taken) begin
            m_pc = branch_target; m_hlt = 1'b0;
            m_vld = 1'b0; m_bun = '0;
        end else begin
            hit = !m_hlt && if_id_write && (mem[m_pc] == 32'hFFFF_FFFF);
            if (if_id_write) begin
                if (m_hlt || hit) begin
                    m_vld = 1'b0;
                end else begin
                    m_vld = 1'b1; m_bun = mem[m_pc]; m_ipc = m_pc;
                end
            end
            if (!m_hlt && pc_write && !hit)
                m_pc = m_pc + 8'd1;
            if (hit)
                m_hlt = 1'b1;
        end
        e.pc = m_pc; e.ipc = m_ipc; e.bun = m_bun;
        e.vld = m_vld; e.hlt = m_hlt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("sb_pc", {24'd0, imem_addr}, {24'd0, e.pc});
            chk("sb_valid", {31'd0, if_id_valid}, {31'd0, e.vld});
            chk("sb_halted", {31'd0, halted}, {31'd0, e.hlt});
            if (e.vld) begin
                chk("sb_ifid_pc", {24'd0, if_id_pc}, {24'd0, e.ipc});
                chk("sb_bundle", if_id_bundle, e.bun);
            end
        end
    endtask

    typedef struct {
        logic [31:0] bun;
        logic        asb;
        logic [2:0]  rd6;
        logic [2:0]  rm;
        logic        mr;
        logic        mw;
        logic [2:0]  rn;
        logic [2:0]  rd;
    } fvec_t;

    fvec_t fv [4];

    initial begin
        fv[0] = '{32'h81E8_C01A, 1'b1, 3'b111, 3'b101, 1'b1, 1'b1, 3'b011, 3'b010};
        fv[1] = '{32'h0000_0000, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000};
        fv[2] = '{32'h7E3F_3FFF, 1'b0, 3'b000, 3'b111, 1'b0, 1'b0, 3'b111, 3'b111};
        fv[3] = '{32'h0001_4005, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 3'b000, 3'b101};

        for (int i = 0; i < 256; i++)
            mem[i] = 32'h1000_0000 | (i << 16) | (i ^ 8'h5A);

        reset = 1'b1; pc_write = 1'b1; if_id_write = 1'b1;
        branch_taken = 1'b0; branch_target = '0;
        #2;
        cycle();
        chk("rst_pc", {24'd0, imem_addr}, 32'd0);
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_bundle", if_id_bundle, 32'd0);
        chk("rst_ifid_pc", {24'd0, if_id_pc}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_fields", {20'd0, f_asb, f_rd6, f_rm, f_mr, f_mw, f_rn, f_rd},
            32'd0);
        reset = 1'b0;

        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("run_ifid_pc", {24'd0, if_id_pc}, k);
            chk("run_valid", {31'd0, if_id_valid}, 32'd1);
        end
        cycle();

        pc_write = 1'b0; if_id_write = 1'b0;
        repeat (2) begin
            cycle();
            chk("stall_pc", {24'd0, imem_addr}, 32'd5);
            chk("stall_ifid_pc", {24'd0, if_id_pc}, 32'd4);
            chk("stall_valid", {31'd0, if_id_valid}, 32'd1);
        end
        pc_write = 1'b1; if_id_write = 1'b1;
        cycle();
        chk("resume_ifid_pc5", {24'd0, if_id_pc}, 32'd5);
        chk("resume_bundle5", if_id_bundle, mem[5]);
        cycle();
        chk("resume_ifid_pc6", {24'd0, if_id_pc}, 32'd6);

        pc_write = 1'b0; if_id_write = 1'b0;
        branch_taken = 1'b1; branch_target = 8'h40;
        cycle();
        chk("br_stall_pc", {24'd0, imem_addr}, 32'h40);
        chk("br_stall_valid", {31'd0, if_id_valid}, 32'd0);
        chk("br_stall_bundle", if_id_bundle, 32'd0);
        chk("br_flush_mr", {31'd0, f_mr}, 32'd0);
        branch_taken = 1'b0; pc_write = 1'b1; if_id_write = 1'b1;
        cycle();
        chk("br_load_pc", {24'd0, if_id_pc}, 32'h40);
        chk("br_load_bundle", if_id_bundle, mem[8'h40]);

        branch_taken = 1'b1; branch_target = 8'hFF;
        cycle();
        branch_taken = 1'b0;
        cycle();
        chk("wrap_pc", {24'd0, imem_addr}, 32'd0);
        chk("wrap_ifid_pc", {24'd0, if_id_pc}, 32'hFF);

        mem[3] = 32'hFFFF_FFFF;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        repeat (3) cycle();
        cycle();
        chk("halt_flag", {31'd0, halted}, 32'd1);
        chk("halt_pc", {24'd0, imem_addr}, 32'd3);
        chk("halt_valid", {31'd0, if_id_valid}, 32'd0);
        repeat (4) begin
            cycle();
            chk("halt_hold_pc", {24'd0, imem_addr}, 32'd3);
            chk("halt_hold_valid", {31'd0, if_id_valid}, 32'd0);
        end
        branch_taken = 1'b1; branch_target = 8'h10;
        cycle();
        chk("unhalt_flag", {31'd0, halted}, 32'd0);
        chk("unhalt_pc", {24'd0, imem_addr}, 32'h10);
        branch_taken = 1'b0;
        cycle();
        chk("unhalt_ifid_pc", {24'd0, if_id_pc}, 32'h10);
        chk("unhalt_valid", {31'd0, if_id_valid}, 32'd1);
        mem[3] = 32'h1003_0059;

        for (int i = 0; i < 4; i++) begin
            mem[8'h80] = fv[i].bun;
            branch_taken = 1'b1; branch_target = 8'h80;
            cycle();
            branch_taken = 1'b0;
            cycle();
            chk("fld_valid", {31'd0, if_id_valid}, 32'd1);
            chk("fld_asb", {31'd0, f_asb}, {31'd0, fv[i].asb});
            chk("fld_rd6", {29'd0, f_rd6}, {29'd0, fv[i].rd6});
            chk("fld_rm", {29'd0, f_rm}, {29'd0, fv[i].rm});
            chk("fld_mr", {31'd0, f_mr}, {31'd0, fv[i].mr});
            chk("fld_mw", {31'd0, f_mw}, {31'd0, fv[i].mw});
            chk("fld_rn1", {29'd0, f_rn}, {29'd0, fv[i].rn});
            chk("fld_rd1", {29'd0, f_rd}, {29'd0, fv[i].rd});
        end
        mem[8'h80] = fv[0].bun;
        branch_taken = 1'b1; branch_target = 8'h80;
        cycle();
        branch_taken = 1'b0;
        cycle();
        chk("pre_flush_mr", {31'd0, f_mr}, 32'd1);
        branch_taken = 1'b1; branch_target = 8'h20;
        cycle();
        branch_taken = 1'b0;
        chk("flush_mr", {31'd0, f_mr}, 32'd0);
        chk("flush_mw", {31'd0, f_mw}, 32'd0);

`ifdef STALL_CNT_EN
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("scnt_rst", {16'd0, stall_count}, 32'd0);
        pc_write = 1'b0;
        repeat (2) cycle();
        if_id_write = 1'b0; pc_write = 1'b1;
        cycle();
        branch_taken = 1'b1; branch_target = 8'h00;
        cycle();
        branch_taken = 1'b0; if_id_write = 1'b1;
        cycle();
        chk("scnt_val", {16'd0, stall_count}, 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
